// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the counter_up_3b family.
//   COUNTER_DEFAULT_W : default counter width (bits)
//   max_count(n)      : terminal count 2^n-1 for an n-bit counter, 1 <= n <= 32
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_W = 3;

    // Saturates at 32 bits so n=32 does not shift the 1 out of range.
    function automatic logic [31:0] max_count(input int unsigned n);
        if (n >= 32) begin
            return '1;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_up_3b.sv
// -----------------------------------------------------------------------------
// counter_up_3b
// Synchronous N-bit binary up-counter with parallel load and synchronous
// active-low reset. Priority per rising edge: reset, then load, then +1
// (modulo 2^N, carry discarded). count_out is purely registered.
//
// Parameters:
//   N            counter width, 1..32 (default COUNTER_DEFAULT_W = 3)
// Ports:
//   clk          rising-edge clock
//   reset_al_in  synchronous active-low reset -> count_out = 0
//   load_in      synchronous parallel load enable (active high)
//   d_in[N-1:0]  value loaded when load_in = 1
//   count_out    registered count value
//   tc_out       registered terminal-count flag, high exactly while
//                count_out == 2^N-1 (present only with COUNTER_UP_TC_EN)
//
// Build option: define COUNTER_UP_TC_EN to add tc_out.
// -----------------------------------------------------------------------------
module counter_up_3b
    import counter_pkg::*;
#(
    parameter int unsigned N = COUNTER_DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         load_in,
    input  logic [N-1:0] d_in,
    output logic [N-1:0] count_out
`ifdef COUNTER_UP_TC_EN
    ,
    output logic         tc_out
`endif
);

    localparam logic [N-1:0] MAX_CNT = N'(max_count(N));

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!reset_al_in) begin
            count_d = '0;
        end else if (load_in) begin
            count_d = d_in;
        end else begin
            count_d = count_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_out = count_q;

`ifdef COUNTER_UP_TC_EN
    logic tc_q;
    logic tc_d;

    // Derived from the next count so the flag lands on the same edge as the
    // value it describes, whether reached by increment or by load.
    always_comb begin
        tc_d = reset_al_in && (count_d == MAX_CNT);
    end

    always_ff @(posedge clk) begin
        tc_q <= tc_d;
    end

    assign tc_out = tc_q;
`endif

endmodule

// File: tb/tb_counter_up_3b.sv
module tb_counter_up_3b;
    import counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Default-width DUT
    logic       rst3_n, ld3;
    logic [2:0] d3, cnt3;
`ifdef COUNTER_UP_TC_EN
    logic       tc3;
`endif

    counter_up_3b #(.N(3)) dut3 (
        .clk         (clk),
        .reset_al_in (rst3_n),
        .load_in     (ld3),
        .d_in        (d3),
        .count_out   (cnt3)
`ifdef COUNTER_UP_TC_EN
        ,
        .tc_out      (tc3)
`endif
    );

    // N=1 DUT
    logic       rst1_n, ld1;
    logic [0:0] d1, cnt1;
`ifdef COUNTER_UP_TC_EN
    logic       tc1;
`endif

    counter_up_3b #(.N(1)) dut1 (
        .clk         (clk),
        .reset_al_in (rst1_n),
        .load_in     (ld1),
        .d_in        (d1),
        .count_out   (cnt1)
`ifdef COUNTER_UP_TC_EN
        ,
        .tc_out      (tc1)
`endif
    );

    // N=8 DUT
    logic       rst8_n, ld8;
    logic [7:0] d8, cnt8;
`ifdef COUNTER_UP_TC_EN
    logic       tc8;
`endif

    counter_up_3b #(.N(8)) dut8 (
        .clk         (clk),
        .reset_al_in (rst8_n),
        .load_in     (ld8),
        .d_in        (d8),
        .count_out   (cnt8)
`ifdef COUNTER_UP_TC_EN
        ,
        .tc_out      (tc8)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       load;
        logic [2:0] d;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [2:0] d, input logic [2:0] e);
        vec_t v;
        v.rst_n = r; v.load = l; v.d = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step1(input logic r, input logic l, input logic [0:0] d, input logic [0:0] e, input string nm);
        rst1_n = r; ld1 = l; d1 = d;
        @(posedge clk); #1;
        check(nm, 32'(cnt1), 32'(e));
`ifdef COUNTER_UP_TC_EN
        check({nm, "_tc"}, 32'(tc1), 32'(e == 1'b1));
`endif
    endtask

    task automatic step8(input logic r, input logic l, input logic [7:0] d, input logic [7:0] e, input string nm);
        rst8_n = r; ld8 = l; d8 = d;
        @(posedge clk); #1;
        check(nm, 32'(cnt8), 32'(e));
`ifdef COUNTER_UP_TC_EN
        check({nm, "_tc"}, 32'(tc8), 32'(e == 8'd255));
`endif
    endtask

    initial begin
        rst3_n = 1'b1; ld3 = 1'b0; d3 = '0;
        rst1_n = 1'b1; ld1 = 1'b0; d1 = '0;
        rst8_n = 1'b1; ld8 = 1'b0; d8 = '0;

        // reset
        add(0, 0, 3'd0, 3'd0);
        add(0, 1, 3'd5, 3'd0);       // reset beats load
        // load then count
        add(1, 1, 3'd0, 3'd0);
        add(1, 0, 3'd0, 3'd1);
        add(1, 0, 3'd0, 3'd2);
        add(1, 0, 3'd0, 3'd3);
        add(1, 0, 3'd0, 3'd4);
        add(1, 0, 3'd0, 3'd5);
        add(1, 0, 3'd0, 3'd6);
        // wrap
        add(1, 1, 3'd6, 3'd6);
        add(1, 0, 3'd0, 3'd7);
        add(1, 0, 3'd0, 3'd0);
        add(1, 0, 3'd0, 3'd1);
        // mid-count reload
        add(1, 0, 3'd0, 3'd2);
        add(1, 0, 3'd0, 3'd3);
        add(1, 1, 3'd2, 3'd2);
        add(1, 0, 3'd0, 3'd3);
        add(1, 0, 3'd0, 3'd4);
        // mid-count reset
        add(1, 0, 3'd0, 3'd5);
        add(0, 0, 3'd0, 3'd0);
        add(1, 0, 3'd0, 3'd1);
        add(1, 0, 3'd0, 3'd2);
        // load held over several edges, then resume
        add(1, 1, 3'd4, 3'd4);
        add(1, 1, 3'd1, 3'd1);
        add(1, 0, 3'd6, 3'd2);       // d ignored without load
        // load of max value
        add(1, 1, 3'd7, 3'd7);
        add(1, 0, 3'd0, 3'd0);
        // reset held with load across two edges
        add(0, 1, 3'd7, 3'd0);
        add(0, 1, 3'd3, 3'd0);
        add(1, 0, 3'd0, 3'd1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst3_n = vecs[i].rst_n;
            ld3    = vecs[i].load;
            d3     = vecs[i].d;
            @(posedge clk); #1;
            check($sformatf("vec%0d_count", i), 32'(cnt3), 32'(vecs[i].exp));
`ifdef COUNTER_UP_TC_EN
            check($sformatf("vec%0d_tc", i), 32'(tc3),
                  32'(32'(vecs[i].exp) == max_count(3)));
`endif
        end

        // No combinational path: changing inputs between edges leaves output alone
        ld3 = 1'b1; d3 = 3'd5;
        #2;
        check("no_comb_path", 32'(cnt3), 32'd1);
        @(posedge clk); #1;
        check("load_after_comb", 32'(cnt3), 32'd5);
        ld3 = 1'b0;

        // N=1 toggles 0,1,0
        step1(0, 0, 1'b0, 1'b0, "n1_reset");
        step1(1, 0, 1'b0, 1'b1, "n1_cnt1");
        step1(1, 0, 1'b0, 1'b0, "n1_cnt2");
        step1(1, 0, 1'b0, 1'b1, "n1_cnt3");
        step1(1, 1, 1'b1, 1'b1, "n1_load1");
        step1(1, 0, 1'b0, 1'b0, "n1_wrap");

        // N=8 wrap and load of 255
        step8(0, 0, 8'd0,   8'd0,   "n8_reset");
        step8(1, 1, 8'd254, 8'd254, "n8_load254");
        step8(1, 0, 8'd0,   8'd255, "n8_inc255");
        step8(1, 0, 8'd0,   8'd0,   "n8_wrap");
        step8(1, 0, 8'd0,   8'd1,   "n8_after_wrap");
        step8(1, 1, 8'd255, 8'd255, "n8_load255");
        step8(1, 0, 8'd0,   8'd0,   "n8_load255_next");
        step8(1, 1, 8'd128, 8'd128, "n8_load128");
        step8(1, 0, 8'd0,   8'd129, "n8_inc129");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
